// File: rtl/step_counter_pkg.sv
// Shared mode and direction encodings for the step counter and its bench.
package step_counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP     = 2'd0,
    MODE_SAT      = 2'd1,
    MODE_PINGPONG = 2'd2,
    MODE_RSVD     = 2'd3
  } mode_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/step_counter_if.sv
// Control and status bundle of the step counter; master drives controls, slave is the counter.
interface step_counter_if #(
  parameter int WIDTH      = 32,
  parameter int STEP_WIDTH = 8,
  parameter int TAP_WIDTH  = 8
);
  logic                  en;
  logic [1:0]            mode;
  logic                  dir;
  logic [STEP_WIDTH-1:0] step;
  logic                  load;
  logic [WIDTH-1:0]      load_value;
  logic [WIDTH-1:0]      count;
  logic [TAP_WIDTH-1:0]  tap;
  logic                  event_pulse;
  logic                  at_limit;
  logic                  cur_dir;

  modport master (
    output en, mode, dir, step, load, load_value,
    input  count, tap, event_pulse, at_limit, cur_dir
  );

  modport slave (
    input  en, mode, dir, step, load, load_value,
    output count, tap, event_pulse, at_limit, cur_dir
  );
endinterface

// File: rtl/step_counter_next.sv
// Combinational next-count, event and direction for one enabled step.
module step_counter_next
  import step_counter_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int STEP_WIDTH = 8
) (
  input  logic [WIDTH-1:0]      count,
  input  logic [STEP_WIDTH-1:0] step,
  input  logic [1:0]            mode,
  input  logic                  dir_eff,
  output logic [WIDTH-1:0]      next_count,
  output logic                  next_event,
  output logic                  next_dir
);
  localparam int EXT_BITS = WIDTH + 1 - STEP_WIDTH;

  logic [WIDTH:0] step_ext;
  logic [WIDTH:0] count_ext;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic [WIDTH:0] s;
  logic [WIDTH:0] max_ext;

  // Bit WIDTH of sum/diff is the carry/borrow out of the counter.
  assign step_ext  = {{EXT_BITS{1'b0}}, step};
  assign count_ext = {1'b0, count};
  assign max_ext   = {1'b0, {WIDTH{1'b1}}};
  assign sum       = count_ext + step_ext;
  assign diff      = count_ext - step_ext;
  assign s         = (dir_eff == DIR_UP) ? sum : diff;

  always_comb begin
    next_count = count;
    next_event = 1'b0;
    next_dir   = dir_eff;
    if (step != '0) begin
      case (mode)
        MODE_SAT: begin
          if (s[WIDTH]) begin
            next_count = (dir_eff == DIR_UP) ? {WIDTH{1'b1}} : '0;
            next_event = 1'b1;
          end else begin
            next_count = s[WIDTH-1:0];
          end
        end
        MODE_PINGPONG: begin
          if (dir_eff == DIR_UP) begin
            if (sum >= max_ext) begin
              next_count = {WIDTH{1'b1}};
              next_dir   = DIR_DOWN;
              next_event = 1'b1;
            end else begin
              next_count = sum[WIDTH-1:0];
            end
          end else begin
            if (count_ext <= step_ext) begin
              next_count = '0;
              next_dir   = DIR_UP;
              next_event = 1'b1;
            end else begin
              next_count = diff[WIDTH-1:0];
            end
          end
        end
        default: begin
          next_count = s[WIDTH-1:0];
          next_event = s[WIDTH];
        end
      endcase
    end
  end
endmodule

// File: rtl/step_counter.sv
// Multi-mode step counter: state registers, load/enable priority and display tap.
module step_counter
  import step_counter_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int STEP_WIDTH = 8,
  parameter int TAP_LSB    = 22,
  parameter int TAP_WIDTH  = 8
) (
  input logic         clk,
  input logic         rst_n,
  step_counter_if.slave bus
);
  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;
  logic             event_reg;
  logic             event_next;
  logic             dir_reg;
  logic             dir_next;

  logic             dir_eff;
  logic [WIDTH-1:0] step_count;
  logic             step_event;
  logic             step_dir;

  // Ping-pong follows its own bounce state; other modes obey the dir input.
  assign dir_eff = (bus.mode == MODE_PINGPONG) ? dir_reg : bus.dir;

  step_counter_next #(
    .WIDTH      (WIDTH),
    .STEP_WIDTH (STEP_WIDTH)
  ) u_next (
    .count      (count_reg),
    .step       (bus.step),
    .mode       (bus.mode),
    .dir_eff    (dir_eff),
    .next_count (step_count),
    .next_event (step_event),
    .next_dir   (step_dir)
  );

  always_comb begin
    count_next = count_reg;
    event_next = 1'b0;
    dir_next   = dir_eff;
    if (bus.load) begin
      count_next = bus.load_value;
      dir_next   = bus.dir;
    end else if (bus.en) begin
      count_next = step_count;
      event_next = step_event;
      dir_next   = step_dir;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
      event_reg <= 1'b0;
      dir_reg   <= DIR_UP;
    end else begin
      count_reg <= count_next;
      event_reg <= event_next;
      dir_reg   <= dir_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < TAP_WIDTH; gi++) begin : g_tap
      assign bus.tap[gi] = count_reg[TAP_LSB + gi];
    end
  endgenerate

  assign bus.count       = count_reg;
  assign bus.event_pulse = event_reg;
  assign bus.cur_dir     = dir_reg;
  assign bus.at_limit    = (count_reg == '0) || (count_reg == {WIDTH{1'b1}});
endmodule

// File: tb/tb_step_counter.sv
// Directed and randomized check of step_counter against an integer reference model.
module tb_step_counter;
  localparam int W  = 8;
  localparam int SW = 4;
  localparam int TL = 4;
  localparam int TW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  step_counter_if #(.WIDTH(W), .STEP_WIDTH(SW), .TAP_WIDTH(TW)) bus ();

  step_counter #(
    .WIDTH      (W),
    .STEP_WIDTH (SW),
    .TAP_LSB    (TL),
    .TAP_WIDTH  (TW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int txn    = 0;
  bit verbose = 1'b1;

  // Reference state: plain integers, one count value and one direction bit.
  int m_count;
  bit m_dir;
  bit m_ev;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h (txn %0d)", tag, obs, exp, txn);
    end
  endtask

  task automatic set_in(input bit en, input int mode, input bit dir, input int step,
                        input bit load, input int lv);
    bus.en         = en;
    bus.mode       = 2'(mode);
    bus.dir        = dir;
    bus.step       = SW'(step);
    bus.load       = load;
    bus.load_value = W'(lv);
  endtask

  task automatic model_reset();
    m_count = 0;
    m_dir   = 1'b1;
    m_ev    = 1'b0;
  endtask

  task automatic model_update();
    int  st;
    int  t;
    int  md;
    bit  d;
    st = int'(bus.step);
    md = int'(bus.mode);
    m_ev = 1'b0;
    if (!rst_n) begin
      model_reset();
    end else if (bus.load) begin
      m_count = int'(bus.load_value);
      m_dir   = bus.dir;
    end else if (!bus.en || st == 0) begin
      if (md != 2) m_dir = bus.dir;
    end else if (md == 2) begin
      if (m_dir) begin
        if (m_count + st >= 255) begin m_count = 255; m_dir = 1'b0; m_ev = 1'b1; end
        else m_count = m_count + st;
      end else begin
        if (m_count <= st) begin m_count = 0; m_dir = 1'b1; m_ev = 1'b1; end
        else m_count = m_count - st;
      end
    end else begin
      d = bus.dir;
      t = d ? m_count + st : m_count - st;
      m_dir = bus.dir;
      if (md == 1) begin
        if (t > 255)    begin m_count = 255; m_ev = 1'b1; end
        else if (t < 0) begin m_count = 0;   m_ev = 1'b1; end
        else m_count = t;
      end else begin
        m_ev    = (t > 255) || (t < 0);
        m_count = (t + 256) % 256;
      end
    end
  endtask

  task automatic compare_outputs(input string tag);
    txn++;
    check_eq({tag, ".count"},    32'(bus.count),       32'(m_count));
    check_eq({tag, ".tap"},      32'(bus.tap),         32'((m_count >> TL) & 15));
    check_eq({tag, ".event"},    32'(bus.event_pulse), 32'(m_ev));
    check_eq({tag, ".at_limit"}, 32'(bus.at_limit),    32'(m_count == 0 || m_count == 255));
    check_eq({tag, ".cur_dir"},  32'(bus.cur_dir),     32'(m_dir));
    if (verbose)
      $display("txn %0d %s count=%02h tap=%0h ev=%0b lim=%0b dir=%0b", txn, tag,
               bus.count, bus.tap, bus.event_pulse, bus.at_limit, bus.cur_dir);
  endtask

  task automatic run_cycle(input string tag);
    @(posedge clk);
    model_update();
    #1;
    compare_outputs(tag);
  endtask

  initial begin
    model_reset();
    set_in(0, 0, 1, 0, 0, 0);
    run_cycle("reset");
    run_cycle("reset");
    rst_n = 1'b1;

    // Load and count, then pull reset asynchronously between edges.
    set_in(0, 0, 1, 0, 1, 'h5A);
    run_cycle("load_5a");
    check_eq("load_5a_const", 32'(bus.count), 32'h5A);
    set_in(1, 0, 1, 1, 0, 0);
    run_cycle("count_up");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_outputs("async_rst");
    check_eq("async_rst_count", 32'(bus.count), 32'h0);
    check_eq("async_rst_dir", 32'(bus.cur_dir), 32'h1);
    run_cycle("rst_hold");
    rst_n = 1'b1;

    set_in(1, 0, 1, 1, 1, 'hC3);
    run_cycle("load_c3");
    check_eq("load_c3_tap", 32'(bus.tap), 32'hC);
    check_eq("load_c3_lim", 32'(bus.at_limit), 32'h0);

    // Wrap up through the top.
    set_in(0, 0, 1, 3, 1, 'hFE);
    run_cycle("wrap_up_ld");
    set_in(1, 0, 1, 3, 0, 0);
    run_cycle("wrap_up");
    check_eq("wrap_up_count", 32'(bus.count), 32'h01);
    check_eq("wrap_up_event", 32'(bus.event_pulse), 32'h1);
    run_cycle("wrap_up2");
    check_eq("wrap_up2_count", 32'(bus.count), 32'h04);

    // Wrap down through zero, then hold with en low.
    set_in(0, 0, 0, 5, 1, 'h02);
    run_cycle("wrap_dn_ld");
    set_in(1, 0, 0, 5, 0, 0);
    run_cycle("wrap_dn");
    check_eq("wrap_dn_count", 32'(bus.count), 32'hFD);
    set_in(0, 0, 0, 5, 0, 0);
    for (int i = 0; i < 3; i++) run_cycle("en_hold");
    check_eq("en_hold_count", 32'(bus.count), 32'hFD);

    // Saturate at the top, repeatedly, then a zero step.
    set_in(0, 1, 1, 15, 1, 'hF8);
    run_cycle("sat_ld");
    set_in(1, 1, 1, 15, 0, 0);
    run_cycle("sat_clamp");
    check_eq("sat_clamp_count", 32'(bus.count), 32'hFF);
    run_cycle("sat_again");
    check_eq("sat_again_event", 32'(bus.event_pulse), 32'h1);
    set_in(1, 1, 1, 0, 0, 0);
    run_cycle("sat_step0");
    check_eq("sat_step0_event", 32'(bus.event_pulse), 32'h0);

    // Ping-pong bounce at the top with the dir input toggling.
    set_in(0, 2, 1, 4, 1, 'hFA);
    run_cycle("pp_ld");
    set_in(1, 2, 1, 4, 0, 0);
    run_cycle("pp_fe");
    set_in(1, 2, 0, 4, 0, 0);
    run_cycle("pp_ff");
    check_eq("pp_ff_count", 32'(bus.count), 32'hFF);
    check_eq("pp_ff_dir", 32'(bus.cur_dir), 32'h0);
    set_in(1, 2, 1, 4, 0, 0);
    run_cycle("pp_fb");
    check_eq("pp_fb_count", 32'(bus.count), 32'hFB);
    set_in(1, 2, 0, 4, 0, 0);
    run_cycle("pp_f7");
    check_eq("pp_f7_count", 32'(bus.count), 32'hF7);

    // Bounce at the bottom; dir=0 on the input must not matter.
    set_in(0, 2, 0, 4, 1, 'h03);
    run_cycle("pp_ld3");
    set_in(1, 2, 0, 4, 0, 0);
    run_cycle("pp_00");
    check_eq("pp_00_dir", 32'(bus.cur_dir), 32'h1);
    run_cycle("pp_04");
    check_eq("pp_04_count", 32'(bus.count), 32'h04);

    // Load wins over enable; leaving ping-pong hands direction back to dir.
    set_in(1, 2, 1, 7, 1, 'h10);
    run_cycle("load_en");
    check_eq("load_en_count", 32'(bus.count), 32'h10);
    set_in(0, 0, 0, 7, 0, 0);
    run_cycle("mode_sw");
    check_eq("mode_sw_dir", 32'(bus.cur_dir), 32'h0);

    // Random traffic against the model.
    verbose = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      set_in(($urandom % 4) != 0, $urandom % 4, $urandom % 2, $urandom % 16,
             ($urandom % 24) == 0, $urandom % 256);
      if (($urandom % 500) == 0) begin
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare_outputs("rand_rst");
        run_cycle("rand_rst_hold");
        rst_n = 1'b1;
      end else begin
        run_cycle("rand");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/step_counter.md
Name: step_counter

Overview:
- Parametrised multi-mode step counter. Adds or subtracts a runtime step on every enabled clock.
- Three limit modes:
  - wrap: modulo 2^WIDTH.
  - saturate: clamps at the bounds.
  - ping-pong: bounces between 0 and the maximum, reversing direction internally.
- Exposes the full count, a parametrised tap slice for direct LED/display drive, and event flags.
- Sits between board inputs (switches/buttons) and display outputs in board-level tops. It replaces the plain free-running/incrementing counter.

Parameters:
- WIDTH, 32, counter width in bits (>= 2).
- STEP_WIDTH, 8, step input width; must be <= WIDTH.
- TAP_LSB, 22, lowest count bit copied to tap.
- TAP_WIDTH, 8, tap width; TAP_LSB+TAP_WIDTH <= WIDTH.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  count enable.
- mode  in  2  0=wrap, 1=saturate, 2=ping-pong, 3=reserved (behaves as wrap).
- dir  in  1  1=up, 0=down. Used directly in wrap/saturate; seeds direction in ping-pong.
- step  in  STEP_WIDTH  unsigned step magnitude, zero-extended.
- load  in  1  synchronous load strobe.
- load_value  in  WIDTH  value loaded when load=1.
- count  out  WIDTH  registered counter value.
- tap  out  TAP_WIDTH  count[TAP_LSB+TAP_WIDTH-1:TAP_LSB], combinational from count.
- event_pulse  out  1  registered one-cycle flag: wrap (mode 0/3), clamp (mode 1) or turn (mode 2).
- at_limit  out  1  combinational: count==0 or count==MAX (MAX = 2^WIDTH-1).
- cur_dir  out  1  effective direction state (1=up).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - count=0, event_pulse=0, dir_state=1 (up).
  - Release is sampled on the next rising clk edge.
- Priority per cycle: load > en > hold.
- load=1:
  - count<=load_value, event_pulse<=0, dir_state<=dir, regardless of en or mode.
- en=0 and load=0:
  - count holds, event_pulse<=0.
  - dir_state<=dir if mode!=2, otherwise holds.
- en=1, step==0: count holds, event_pulse<=0, no direction flip in any mode.
- en=1, step!=0: compute s = {1'b0,count} +/- zext(step) in WIDTH+1 bits. The effective direction d is dir in modes 0/1/3 and dir_state in mode 2.
  - Wrap: count<=s[WIDTH-1:0]. event_pulse<=1 iff carry-out (up) or borrow (down).
  - Saturate: on overflow count<=MAX, on underflow count<=0, else s. event_pulse<=1 only on a cycle where clamping occurred. A count already at a bound and pushed further clamps again and pulses again.
  - Ping-pong, up: if count+step >= MAX, then count<=MAX, dir_state<=0, event_pulse<=1; else count<=s.
  - Ping-pong, down: if count <= step, then count<=0, dir_state<=1, event_pulse<=1; else count<=s.
  - The dir input is ignored in mode 2 except via load.
- Modes 0/1/3: dir_state<=dir every cycle, so entering ping-pong starts in the last commanded direction.
- Latency: inputs to count takes one cycle. tap and at_limit are same-cycle as count. event_pulse is registered alongside count, so it is asserted in the same cycle the new count appears.
- Mode change mid-run takes effect on the same edge it is sampled; no internal flush.
- Reset asserted mid-operation forces reset values immediately, independent of clk.
- Width rules:
  - All arithmetic is unsigned.
  - step is zero-extended to WIDTH+1.
  - No truncation warnings are permitted; the extra bit is the carry/borrow.

Decomposition:
- Shared package/include step_counter_defs:
  - MODE_WRAP=2'd0, MODE_SAT=2'd1, MODE_PINGPONG=2'd2, MODE_RSVD=2'd3.
  - DIR_UP=1'b1, DIR_DOWN=1'b0.
- One natural sub-module: step_counter_next.
  - Purely combinational.
  - Inputs: count, step, mode, effective dir.
  - Outputs: next count, event, next dir.
- The top module holds registers, load/enable priority and the tap slice.

Test Plan (WIDTH=8, STEP_WIDTH=4, TAP_LSB=4, TAP_WIDTH=4):
- Reset/load: assert rst_n=0 mid-count at 0x5A -> count=0, event_pulse=0, cur_dir=1 asynchronously. Then load=1, load_value=0xC3 -> count=0xC3, tap=0xC, at_limit=0 next cycle.
- Wrap up: mode=0, dir=1, step=3, count=0xFE -> next count=0x01, event_pulse=1 one cycle. Following step -> 0x04, event_pulse=0.
- Wrap down with en gating:
  - dir=0, step=5, count=0x02 -> count=0xFD, event_pulse=1.
  - en=0 for 3 cycles -> count holds 0xFD, event_pulse=0.
- Saturate:
  - mode=1, dir=1, step=15, count=0xF8 -> count=0xFF, event_pulse=1, at_limit=1.
  - Next enabled cycle -> stays 0xFF, event_pulse=1.
  - step=0 -> stays 0xFF, event_pulse=0.
- Ping-pong bounce:
  - mode=2, load 0xFA with dir=1, step=4 -> 0xFE, then 0xFF with cur_dir=0 and event_pulse=1, then 0xFB, 0xF7.
  - Load 0x03 with dir=0 -> 0x00 with cur_dir=1 and event_pulse=1, then 0x04.
  - Toggling dir input while in mode 2 has no effect.
- Simultaneous load+en: load=1, en=1, step=7, load_value=0x10 -> count=0x10, not 0x17. Switching mode 2->0 with dir=0 -> cur_dir follows dir next cycle.
